mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client arbiter for a dual-read-port RAM with registered read data.
// Round-robin on ties, optional client lock, reads take two cycles and writes one.
`timescale 1ns/1ps

`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 10
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif

module mem_arbiter #(
    parameter int ADDR_W = `MEMORY_ADDR_WIDTH,
    parameter int DATA_W = `MEMORY_DATA_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic              c0_lock,
    input  logic [ADDR_W-1:0] c0_addr1,
    input  logic [ADDR_W-1:0] c0_addr2,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_gnt,
    output logic              c0_rvalid,
    output logic [DATA_W-1:0] c0_rdata1,
    output logic [DATA_W-1:0] c0_rdata2,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic              c1_lock,
    input  logic [ADDR_W-1:0] c1_addr1,
    input  logic [ADDR_W-1:0] c1_addr2,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_gnt,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] c1_rdata1,
    output logic [DATA_W-1:0] c1_rdata2,
    output logic [ADDR_W-1:0] ram_addr1,
    output logic [ADDR_W-1:0] ram_addr2,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q1,
    input  logic [DATA_W-1:0] ram_q2,
    output logic              busy
);

    typedef enum logic [0:0] {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_C0   = 2'd1;
    localparam logic [1:0] OWN_C1   = 2'd2;

    state_t            state_r, state_nxt_s;
    logic [1:0]        owner_r, owner_nxt_s;
    logic              rr_last_r, rr_last_nxt_s;      // 0 = c0, 1 = c1
    logic              rd_client_r, rd_client_nxt_s;  // target of the read in flight
    logic [DATA_W-1:0] c0_rdata1_r, c0_rdata2_r, c1_rdata1_r, c1_rdata2_r;
    logic              gnt0_s, gnt1_s, grant_s, winner_s;
    logic              win_we_s, win_lock_s;

    // Arbitration: grants only from IDLE; an owner excludes the other client.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if ((state_r == IDLE) && !reset) begin
            case (owner_r)
                OWN_C0:   gnt0_s = c0_req;
                OWN_C1:   gnt1_s = c1_req;
                OWN_NONE: begin
                    if (c0_req && c1_req) begin
                        gnt0_s = rr_last_r;
                        gnt1_s = ~rr_last_r;
                    end else begin
                        gnt0_s = c0_req;
                        gnt1_s = c1_req;
                    end
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign grant_s  = gnt0_s | gnt1_s;
    assign winner_s = gnt1_s;

    // RAM port mux: winner's fields during a grant, all zero otherwise.
    always_comb begin
        ram_addr1  = {ADDR_W{1'b0}};
        ram_addr2  = {ADDR_W{1'b0}};
        ram_data   = {DATA_W{1'b0}};
        ram_wren   = 1'b0;
        win_we_s   = 1'b0;
        win_lock_s = 1'b0;
        if (gnt0_s) begin
            ram_addr1  = c0_addr1;
            ram_addr2  = c0_addr2;
            ram_data   = c0_wdata;
            ram_wren   = c0_we;
            win_we_s   = c0_we;
            win_lock_s = c0_lock;
        end else if (gnt1_s) begin
            ram_addr1  = c1_addr1;
            ram_addr2  = c1_addr2;
            ram_data   = c1_wdata;
            ram_wren   = c1_we;
            win_we_s   = c1_we;
            win_lock_s = c1_lock;
        end else begin
            ram_wren   = 1'b0;
        end
    end

    // Next state, ownership and round-robin bookkeeping.
    always_comb begin
        state_nxt_s     = state_r;
        owner_nxt_s     = owner_r;
        rr_last_nxt_s   = rr_last_r;
        rd_client_nxt_s = rd_client_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    rr_last_nxt_s = winner_s;
                    owner_nxt_s   = win_lock_s ? (winner_s ? OWN_C1 : OWN_C0) : OWN_NONE;
                    if (!win_we_s) begin
                        state_nxt_s     = RD_WAIT;
                        rd_client_nxt_s = winner_s;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_WAIT: state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State registers; the read data is latched into the target's holding registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            owner_r     <= OWN_NONE;
            rr_last_r   <= 1'b1;
            rd_client_r <= 1'b0;
            c0_rdata1_r <= {DATA_W{1'b0}};
            c0_rdata2_r <= {DATA_W{1'b0}};
            c1_rdata1_r <= {DATA_W{1'b0}};
            c1_rdata2_r <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            owner_r     <= owner_nxt_s;
            rr_last_r   <= rr_last_nxt_s;
            rd_client_r <= rd_client_nxt_s;
            if (state_r == RD_WAIT) begin
                if (rd_client_r) begin
                    c1_rdata1_r <= ram_q1;
                    c1_rdata2_r <= ram_q2;
                end else begin
                    c0_rdata1_r <= ram_q1;
                    c0_rdata2_r <= ram_q2;
                end
            end
        end
    end

    // RAM data is forwarded in the rvalid cycle and held afterwards.
    assign c0_gnt    = gnt0_s;
    assign c1_gnt    = gnt1_s;
    assign c0_rvalid = (state_r == RD_WAIT) && !rd_client_r;
    assign c1_rvalid = (state_r == RD_WAIT) && rd_client_r;
    assign c0_rdata1 = c0_rvalid ? ram_q1 : c0_rdata1_r;
    assign c0_rdata2 = c0_rvalid ? ram_q2 : c0_rdata2_r;
    assign c1_rdata1 = c1_rvalid ? ram_q1 : c1_rdata1_r;
    assign c1_rdata2 = c1_rvalid ? ram_q2 : c1_rdata2_r;
    assign busy      = (state_r != IDLE) || (owner_r != OWN_NONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, reference memory and per-client read scoreboards.
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          c0_req, c0_we, c0_lock, c1_req, c1_we, c1_lock;
    logic [AW-1:0] c0_addr1, c0_addr2, c1_addr1, c1_addr2;
    logic [DW-1:0] c0_wdata, c1_wdata;
    logic          c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
    logic [DW-1:0] c0_rdata1, c0_rdata2, c1_rdata1, c1_rdata2;
    logic [AW-1:0] ram_addr1, ram_addr2;
    logic [DW-1:0] ram_data, ram_q1, ram_q2;
    logic          ram_wren, busy;

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .c0_req(c0_req), .c0_we(c0_we), .c0_lock(c0_lock), .c0_addr1(c0_addr1), .c0_addr2(c0_addr2),
        .c0_wdata(c0_wdata), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata1(c0_rdata1), .c0_rdata2(c0_rdata2),
        .c1_req(c1_req), .c1_we(c1_we), .c1_lock(c1_lock), .c1_addr1(c1_addr1), .c1_addr2(c1_addr2),
        .c1_wdata(c1_wdata), .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata1(c1_rdata1), .c1_rdata2(c1_rdata2),
        .ram_addr1(ram_addr1), .ram_addr2(ram_addr2), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q1(ram_q1), .ram_q2(ram_q2), .busy(busy)
    );

    always #5 clock = ~clock;

    // Synchronous RAM with registered read data.
    always @(posedge clock) begin
        if (ram_wren) ram[ram_addr1] <= ram_data;
        ram_q1 <= ram[ram_addr1];
        ram_q2 <= ram[ram_addr2];
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     <= 16'(i * 37 + 5);
            ref_mem[i]  = 16'(i * 37 + 5);
        end
    end

    // Scoreboard: compare every rvalid against the oldest expected read; check exclusivity.
    always @(negedge clock) begin
        #2;
        if (c0_rvalid) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL c0_unexpected_rvalid got rdata1=%h with no read outstanding", c0_rdata1);
            end else begin
                mon_e = q0.pop_front();
                if (c0_rdata1 !== mon_e.d1 || c0_rdata2 !== mon_e.d2) begin
                    errors++;
                    $display("FAIL c0_rdata got %h/%h exp %h/%h", c0_rdata1, c0_rdata2, mon_e.d1, mon_e.d2);
                end
            end
        end
        if (c1_rvalid) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL c1_unexpected_rvalid got rdata1=%h with no read outstanding", c1_rdata1);
            end else begin
                mon_e = q1.pop_front();
                if (c1_rdata1 !== mon_e.d1 || c1_rdata2 !== mon_e.d2) begin
                    errors++;
                    $display("FAIL c1_rdata got %h/%h exp %h/%h", c1_rdata1, c1_rdata2, mon_e.d1, mon_e.d2);
                end
            end
        end
        checks++;
        if ((c0_gnt && c1_gnt) || (c0_rvalid && c1_rvalid) || (c0_gnt && c0_rvalid) || (c1_gnt && c1_rvalid)) begin
            errors++;
            $display("FAIL exclusive got gnt=%b%b rvalid=%b%b exp at most one, never gnt+rvalid same client",
                     c0_gnt, c1_gnt, c0_rvalid, c1_rvalid);
        end
    end

    task automatic clear_inputs();
        c0_req = 1'b0; c0_we = 1'b0; c0_lock = 1'b0; c0_addr1 = 10'h000; c0_addr2 = 10'h000; c0_wdata = 16'h0000;
        c1_req = 1'b0; c1_we = 1'b0; c1_lock = 1'b0; c1_addr1 = 10'h000; c1_addr2 = 10'h000; c1_wdata = 16'h0000;
    endtask

    task automatic pulse_reset();
        @(negedge clock); reset = 1'b1; clear_inputs();
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        c0_req = 1'b1;
        @(negedge clock); #1;
        checks++; if ({c0_gnt, c1_gnt} !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b exp 00", {c0_gnt, c1_gnt}); end
        checks++; if ({c0_rvalid, c1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", {c0_rvalid, c1_rvalid}); end
        checks++; if (c0_rdata1 !== 16'h0000 || c1_rdata2 !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h/%h exp 0", c0_rdata1, c1_rdata2); end
        checks++; if (ram_wren !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_wren_busy got %b%b exp 00", ram_wren, busy); end
        c0_req = 1'b0;
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_two_reads();
        c0_req = 1'b1; c0_addr1 = 10'h010; c0_addr2 = 10'h011;
        c1_req = 1'b1; c1_addr1 = 10'h020; c1_addr2 = 10'h021;
        #1;
        checks++; if ({c0_gnt, c1_gnt} !== 2'b10) begin errors++; $display("FAIL tr_cyc0_gnt got %b exp 10", {c0_gnt, c1_gnt}); end
        checks++; if (ram_addr1 !== 10'h010 || ram_addr2 !== 10'h011 || ram_wren !== 1'b0) begin
            errors++; $display("FAIL tr_cyc0_ram got %h/%h/%b exp 010/011/0", ram_addr1, ram_addr2, ram_wren); end
        q0.push_back('{ref_mem[10'h010], ref_mem[10'h011]});
        @(negedge clock); c0_req = 1'b0; #1;
        checks++; if ({c0_gnt, c1_gnt} !== 2'b00 || c0_rvalid !== 1'b1) begin
            errors++; $display("FAIL tr_cyc1 got gnt=%b rv0=%b exp 00 1", {c0_gnt, c1_gnt}, c0_rvalid); end
        checks++; if (busy !== 1'b1 || ram_addr1 !== 10'h000 || ram_wren !== 1'b0) begin
            errors++; $display("FAIL tr_cyc1_idle_bus got busy=%b addr=%h wren=%b exp 1 000 0", busy, ram_addr1, ram_wren); end
        checks++; if (c1_rdata1 !== 16'h0000) begin errors++; $display("FAIL tr_c1_untouched got %h exp 0000", c1_rdata1); end
        @(negedge clock); #1;
        checks++; if ({c0_gnt, c1_gnt} !== 2'b01) begin errors++; $display("FAIL tr_cyc2_gnt got %b exp 01", {c0_gnt, c1_gnt}); end
        q1.push_back('{ref_mem[10'h020], ref_mem[10'h021]});
        @(negedge clock); c1_req = 1'b0; #1;
        checks++; if ({c0_rvalid, c1_rvalid} !== 2'b01) begin errors++; $display("FAIL tr_cyc3_rvalid got %b exp 01", {c0_rvalid, c1_rvalid}); end
        checks++; if (c0_rdata1 !== ref_mem[10'h010]) begin errors++; $display("FAIL tr_c0_hold got %h exp %h", c0_rdata1, ref_mem[10'h010]); end
    endtask

    task automatic test_write_read();
        int wren_cnt = 0;
        @(negedge clock);
        c1_req = 1'b1; c1_we = 1'b1; c1_addr1 = 10'h005; c1_wdata = 16'hDEAD;
        #1;
        checks++; if (c1_gnt !== 1'b1 || ram_wren !== 1'b1 || ram_addr1 !== 10'h005 || ram_data !== 16'hDEAD) begin
            errors++; $display("FAIL wr_grant got gnt=%b wren=%b addr=%h data=%h exp 1 1 005 dead", c1_gnt, ram_wren, ram_addr1, ram_data); end
        if (ram_wren) wren_cnt++;
        ref_mem[10'h005] = 16'hDEAD;
        @(negedge clock);
        c1_req = 1'b0; c1_we = 1'b0;
        c0_req = 1'b1; c0_we = 1'b0; c0_addr1 = 10'h005; c0_addr2 = 10'h006;
        #1;
        checks++; if (c0_gnt !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wr_rd_gnt got gnt=%b busy=%b exp 1 0", c0_gnt, busy); end
        if (ram_wren) wren_cnt++;
        q0.push_back('{ref_mem[10'h005], ref_mem[10'h006]});
        @(negedge clock); c0_req = 1'b0; #1;
        if (ram_wren) wren_cnt++;
        checks++; if (c0_rvalid !== 1'b1 || c0_rdata1 !== 16'hDEAD) begin
            errors++; $display("FAIL wr_rd_data got rv=%b d1=%h exp 1 dead", c0_rvalid, c0_rdata1); end
        checks++; if (wren_cnt != 1) begin errors++; $display("FAIL wr_wren_cycles got %0d exp 1", wren_cnt); end
        @(negedge clock); #1;
        checks++; if (c0_rvalid !== 1'b0 || c0_rdata1 !== 16'hDEAD) begin
            errors++; $display("FAIL wr_rd_hold got rv=%b d1=%h exp 0 dead", c0_rvalid, c0_rdata1); end
    endtask

    task automatic test_round_robin();
        logic exp1;
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            c0_req = 1'b1; c0_we = 1'b0; c0_addr1 = 10'h040 + 10'(i); c0_addr2 = 10'h050 + 10'(i);
            c1_req = 1'b1; c1_we = 1'b0; c1_addr1 = 10'h080 + 10'(i); c1_addr2 = 10'h090 + 10'(i);
            exp1 = (i % 2) == 1;
            #1;
            checks++; if ({c0_gnt, c1_gnt} !== {~exp1, exp1}) begin
                errors++; $display("FAIL rr_gnt_%0d got %b exp %b", i, {c0_gnt, c1_gnt}, {~exp1, exp1}); end
            if (exp1) q1.push_back('{ref_mem[c1_addr1], ref_mem[c1_addr2]});
            else      q0.push_back('{ref_mem[c0_addr1], ref_mem[c0_addr2]});
            @(negedge clock); #1;
            checks++; if ({c0_gnt, c1_gnt} !== 2'b00 || {c0_rvalid, c1_rvalid} !== {~exp1, exp1}) begin
                errors++; $display("FAIL rr_wait_%0d got gnt=%b rv=%b exp 00 %b", i, {c0_gnt, c1_gnt}, {c0_rvalid, c1_rvalid}, {~exp1, exp1}); end
            @(negedge clock);
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        c0_req = 1'b1; c0_we = 1'b0; c0_lock = 1'b1; c0_addr1 = 10'h100; c0_addr2 = 10'h101;
        c1_req = 1'b1; c1_we = 1'b1; c1_addr1 = 10'h030; c1_wdata = 16'h1234;
        #1;
        checks++; if ({c0_gnt, c1_gnt} !== 2'b10) begin errors++; $display("FAIL lk_first got %b exp 10", {c0_gnt, c1_gnt}); end
        q0.push_back('{ref_mem[10'h100], ref_mem[10'h101]});
        @(negedge clock); c0_req = 1'b0; c0_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({c0_gnt, c1_gnt} !== 2'b00 || busy !== 1'b1) begin
                errors++; $display("FAIL lk_hold_%0d got gnt=%b busy=%b exp 00 1", i, {c0_gnt, c1_gnt}, busy); end
            @(negedge clock);
        end
        c0_req = 1'b1; c0_we = 1'b1; c0_lock = 1'b0; c0_addr1 = 10'h031; c0_wdata = 16'hBEEF;
        #1;
        checks++; if ({c0_gnt, c1_gnt} !== 2'b10 || ram_data !== 16'hBEEF || ram_wren !== 1'b1) begin
            errors++; $display("FAIL lk_unlock_wr got gnt=%b data=%h wren=%b exp 10 beef 1", {c0_gnt, c1_gnt}, ram_data, ram_wren); end
        ref_mem[10'h031] = 16'hBEEF;
        @(negedge clock); c0_req = 1'b0; c0_we = 1'b0; #1;
        checks++; if ({c0_gnt, c1_gnt} !== 2'b01 || ram_addr1 !== 10'h030 || ram_data !== 16'h1234) begin
            errors++; $display("FAIL lk_c1_after got gnt=%b addr=%h data=%h exp 01 030 1234", {c0_gnt, c1_gnt}, ram_addr1, ram_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lk_released_busy got %b exp 0", busy); end
        ref_mem[10'h030] = 16'h1234;
        @(negedge clock); c1_we = 1'b0; c1_addr1 = 10'h030; c1_addr2 = 10'h031; #1;
        q1.push_back('{ref_mem[10'h030], ref_mem[10'h031]});
        @(negedge clock); clear_inputs(); #1;
        checks++; if (c1_rvalid !== 1'b1) begin errors++; $display("FAIL lk_readback_rv got %b exp 1", c1_rvalid); end
    endtask

    task automatic test_reset_rdwait();
        @(negedge clock);
        c0_req = 1'b1; c0_we = 1'b0; c0_addr1 = 10'h200; c0_addr2 = 10'h201;
        #1;
        checks++; if (c0_gnt !== 1'b1) begin errors++; $display("FAIL rw_gnt got %b exp 1", c0_gnt); end
        @(negedge clock); c0_req = 1'b0; reset = 1'b1; #1;
        checks++; if (c0_rvalid !== 1'b0 || busy !== 1'b0 || c0_rdata1 !== 16'h0000) begin
            errors++; $display("FAIL rw_in_reset got rv=%b busy=%b d1=%h exp 0 0 0000", c0_rvalid, busy, c0_rdata1); end
        @(negedge clock); reset = 1'b0; #1;
        checks++; if (c0_rvalid !== 1'b0 || {c0_gnt, c1_gnt} !== 2'b00) begin
            errors++; $display("FAIL rw_after_release got rv=%b gnt=%b exp 0 00", c0_rvalid, {c0_gnt, c1_gnt}); end
        @(negedge clock); c1_req = 1'b1; c1_addr1 = 10'h202; c1_addr2 = 10'h203; #1;
        checks++; if (c1_gnt !== 1'b1) begin errors++; $display("FAIL rw_next_gnt got %b exp 1", c1_gnt); end
        q1.push_back('{ref_mem[10'h202], ref_mem[10'h203]});
        @(negedge clock); c1_req = 1'b0; #1;
        checks++; if (c1_rvalid !== 1'b1) begin errors++; $display("FAIL rw_next_rv got %b exp 1", c1_rvalid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            c0_req = 1'b1; c0_we = 1'b1; c0_addr1 = 10'(i); c0_addr2 = 10'h000; c0_wdata = 16'hA000 + 16'(i);
            #1;
            checks++; if (c0_gnt !== 1'b1 || busy !== 1'b0 || ram_wren !== 1'b1 || ram_addr1 !== 10'(i)) begin
                errors++; $display("FAIL b2b_%0d got gnt=%b busy=%b wren=%b addr=%h exp 1 0 1 %h", i, c0_gnt, busy, ram_wren, ram_addr1, 10'(i)); end
            ref_mem[10'(i)] = 16'hA000 + 16'(i);
        end
        @(negedge clock); c0_we = 1'b0; c0_addr1 = 10'h000; c0_addr2 = 10'h007; #1;
        q0.push_back('{ref_mem[10'h000], ref_mem[10'h007]});
        @(negedge clock); clear_inputs(); #1;
        checks++; if (c0_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_readback_rv got %b exp 1", c0_rvalid); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_two_reads();
        test_write_read();
        test_round_robin();
        test_lock();
        test_reset_rdwait();
        test_back_to_back();
        repeat (3) @(negedge clock);
        #3;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++; $display("FAIL missing_rvalid got %0d/%0d outstanding exp 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
